// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shift scoreboard of in-flight destination registers that produces
// the load-use decode stall and the EX forward selects. `define HAZARD_STATS_EN adds stall/flush counters.
module hazard_scoreboard #(
    parameter  int AW         = 5,
    parameter  int FWD_STAGES = 3,
    parameter  int LOAD_STAGE = 1,
    localparam int FSW        = $clog2(FWD_STAGES)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           id_valid,
    input  logic [AW-1:0]  id_rs1,
    input  logic [AW-1:0]  id_rs2,
    input  logic           id_rs1_used,
    input  logic           id_rs2_used,
    input  logic [AW-1:0]  id_rd,
    input  logic           id_regwrite,
    input  logic           id_memread,
    input  logic           flush,
    output logic           stall,
    output logic [FSW-1:0] fwd_a,
    output logic [FSW-1:0] fwd_b,
`ifdef HAZARD_STATS_EN
    output logic [31:0]    stall_cnt,
    output logic [31:0]    flush_cnt,
`endif
    output logic [AW-1:0]  ex_rd
);
    logic [FWD_STAGES-1:0] sb_valid;
    logic [FWD_STAGES-1:0] sb_regwrite;
    logic [FWD_STAGES-1:0] sb_load;
    logic [AW-1:0]         sb_rd [FWD_STAGES];
    logic [AW-1:0]         ex_rs1;
    logic [AW-1:0]         ex_rs2;
    logic                  ex_rs1_used;
    logic                  ex_rs2_used;
    logic [FWD_STAGES-1:0] producer;
    logic                  load_hit;
    logic                  issue;

    always_comb begin
        producer = '0;
        for (int unsigned k = 0; k < FWD_STAGES; k++)
            producer[k] = sb_valid[k] && sb_regwrite[k] && (sb_rd[k] != '0);
    end

    // A load still younger than LOAD_STAGE cannot reach EX in time for its consumer.
    always_comb begin
        load_hit = 1'b0;
        for (int unsigned k = 0; k < LOAD_STAGE; k++) begin
            if (producer[k] && sb_load[k] &&
                ((id_rs1_used && sb_rd[k] == id_rs1) || (id_rs2_used && sb_rd[k] == id_rs2)))
                load_hit = 1'b1;
        end
    end

    assign stall = rst && id_valid && !flush && load_hit;
    assign issue = id_valid && !stall && !flush;

    // Scan oldest to youngest so the youngest matching producer is the one left selected.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int unsigned k = FWD_STAGES - 1; k >= 1; k--) begin
            if (producer[k] && sb_rd[k] == ex_rs1) fwd_a = FSW'(k);
            if (producer[k] && sb_rd[k] == ex_rs2) fwd_b = FSW'(k);
        end
        if (!ex_rs1_used) fwd_a = '0;
        if (!ex_rs2_used) fwd_b = '0;
    end

    assign ex_rd = (sb_valid[0] && sb_regwrite[0]) ? sb_rd[0] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_valid    <= '0;
            sb_regwrite <= '0;
            sb_load     <= '0;
            for (int unsigned k = 0; k < FWD_STAGES; k++)
                sb_rd[k] <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rs1_used <= 1'b0;
            ex_rs2_used <= 1'b0;
        end else begin
            sb_valid    <= {sb_valid[FWD_STAGES-2:0], issue};
            sb_regwrite <= {sb_regwrite[FWD_STAGES-2:0], issue && id_regwrite};
            sb_load     <= {sb_load[FWD_STAGES-2:0], issue && id_memread};
            for (int unsigned k = FWD_STAGES - 1; k >= 1; k--)
                sb_rd[k] <= sb_rd[k-1];
            sb_rd[0]    <= issue ? id_rd : '0;
            ex_rs1      <= issue ? id_rs1 : '0;
            ex_rs2      <= issue ? id_rs2 : '0;
            ex_rs1_used <= issue && id_rs1_used;
            ex_rs2_used <= issue && id_rs2_used;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two configurations (3 stages/load 1 and 4 stages/load 2) share
// one stimulus stream; an age-list model predicts every output each cycle.
`timescale 1ns/1ps
module tb_hazard_scoreboard;
    typedef struct {
        int         age;
        logic       v;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       rw;
        logic       ld;
    } inst_t;
    typedef inst_t iq_t[$];

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       flush;
    logic       stall0, stall1;
    logic [1:0] fa0, fb0, fa1, fb1;
    logic [4:0] exrd0, exrd1;
`ifdef HAZARD_STATS_EN
    logic [31:0] scnt0, fcnt0, scnt1, fcnt1;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic       last_stall0, last_stall1;
    logic [1:0] last_fa0, last_fb0, last_fa1, last_fb1;
    logic [4:0] last_exrd0, last_exrd1;

    hazard_scoreboard #(.AW(5), .FWD_STAGES(3), .LOAD_STAGE(1)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .stall(stall0), .fwd_a(fa0), .fwd_b(fb0),
`ifdef HAZARD_STATS_EN
        .stall_cnt(scnt0), .flush_cnt(fcnt0),
`endif
        .ex_rd(exrd0));

    hazard_scoreboard #(.AW(5), .FWD_STAGES(4), .LOAD_STAGE(2)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .stall(stall1), .fwd_a(fa1), .fwd_b(fb1),
`ifdef HAZARD_STATS_EN
        .stall_cnt(scnt1), .flush_cnt(fcnt1),
`endif
        .ex_rd(exrd1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each in-flight instruction carries its age in cycles since it entered EX.
    function automatic logic m_stall(input iq_t q, input int ls);
        if (!rst || !id_valid || flush) return 1'b0;
        foreach (q[i])
            if (q[i].age < ls && q[i].ld && q[i].rw && q[i].rd != 0 &&
                ((id_rs1_used && q[i].rd == id_rs1) || (id_rs2_used && q[i].rd == id_rs2)))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_fwd(input iq_t q, input bit second);
        logic [4:0] src;
        logic       used;
        int         best;
        src = '0;
        used = 1'b0;
        best = 0;
        foreach (q[i])
            if (q[i].age == 0) begin
                src  = second ? q[i].rs2 : q[i].rs1;
                used = second ? q[i].u2 : q[i].u1;
            end
        if (!used || src == 0) return 0;
        foreach (q[i])
            if (q[i].age >= 1 && q[i].rw && q[i].rd == src && (best == 0 || q[i].age < best))
                best = q[i].age;
        return best;
    endfunction

    function automatic int m_exrd(input iq_t q);
        foreach (q[i])
            if (q[i].age == 0 && q[i].rw) return int'(q[i].rd);
        return 0;
    endfunction

    function automatic iq_t advance(input iq_t q, input int depth, input logic iss);
        iq_t   r;
        inst_t n;
        foreach (q[i])
            if (q[i].age + 1 < depth) begin
                n = q[i];
                n.age = n.age + 1;
                r.push_back(n);
            end
        if (iss) begin
            n.age = 0; n.v = 1'b1; n.rd = id_rd; n.rs1 = id_rs1; n.rs2 = id_rs2;
            n.u1 = id_rs1_used; n.u2 = id_rs2_used; n.rw = id_regwrite; n.ld = id_memread;
            r.push_back(n);
        end
        return r;
    endfunction

    iq_t  q0, q1;
    logic iss0, iss1;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q0.delete();
            q1.delete();
        end else begin
            iss0 = id_valid && !flush && !m_stall(q0, 1);
            iss1 = id_valid && !flush && !m_stall(q1, 2);
            q0 = advance(q0, 3, iss0);
            q1 = advance(q1, 4, iss1);
        end
    end

    function automatic inst_t mk(input int rd, input int rs1, input int rs2,
                                 input bit u1, input bit u2, input bit rw, input bit ld);
        inst_t i;
        i.age = 0; i.v = 1'b1; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
        i.u1 = u1; i.u2 = u2; i.rw = rw; i.ld = ld;
        return i;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_id(input inst_t i, input logic fl);
        id_valid = i.v; id_rd = i.rd; id_rs1 = i.rs1; id_rs2 = i.rs2;
        id_rs1_used = i.u1; id_rs2_used = i.u2; id_regwrite = i.rw; id_memread = i.ld;
        flush = fl;
    endtask

    task automatic compare_all();
        chk("stall0", 32'(stall0), 32'(m_stall(q0, 1)));
        chk("fwd_a0", 32'(fa0), m_fwd(q0, 1'b0));
        chk("fwd_b0", 32'(fb0), m_fwd(q0, 1'b1));
        chk("ex_rd0", 32'(exrd0), m_exrd(q0));
        chk("stall1", 32'(stall1), 32'(m_stall(q1, 2)));
        chk("fwd_a1", 32'(fa1), m_fwd(q1, 1'b0));
        chk("fwd_b1", 32'(fb1), m_fwd(q1, 1'b1));
        chk("ex_rd1", 32'(exrd1), m_exrd(q1));
        last_stall0 = stall0; last_fa0 = fa0; last_fb0 = fb0; last_exrd0 = exrd0;
        last_stall1 = stall1; last_fa1 = fa1; last_fb1 = fb1; last_exrd1 = exrd1;
    endtask

    task automatic step(input inst_t i, input logic fl);
        set_id(i, fl);
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    // Hold an instruction in ID until the chosen DUT stops stalling it.
    task automatic hold(input inst_t i, input bit on_dut1, output int stalls);
        stalls = 0;
        for (int n = 0; n < 8; n++) begin
            step(i, 1'b0);
            if (!(on_dut1 ? last_stall1 : last_stall0)) return;
            stalls++;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL hold_timeout: got stall after %0d cycles, expected release", stalls);
    endtask

    inst_t nop, lw5, add6, add5a, sub7, add5b, or8, lw0, add9, lw3, add4;

    task automatic drain();
        repeat (4) step(nop, 1'b0);
    endtask

    initial begin
        int ns;
`ifdef HAZARD_STATS_EN
        logic [31:0] c0;
`endif
        nop   = mk(0, 0, 0, 0, 0, 0, 0);
        nop.v = 1'b0;
        lw5   = mk(5, 1, 0, 1, 0, 1, 1);
        add6  = mk(6, 5, 1, 1, 1, 1, 0);
        add5a = mk(5, 1, 2, 1, 1, 1, 0);
        sub7  = mk(7, 5, 5, 1, 1, 1, 0);
        add5b = mk(5, 3, 4, 1, 1, 1, 0);
        or8   = mk(8, 5, 0, 1, 1, 1, 0);
        lw0   = mk(0, 1, 0, 1, 0, 1, 1);
        add9  = mk(9, 0, 0, 1, 1, 1, 0);
        lw3   = mk(3, 1, 0, 1, 0, 1, 1);
        add4  = mk(4, 3, 3, 1, 1, 1, 0);

        rst = 1'b0;
        set_id(nop, 1'b0);
        #2;
        chk("reset_stall", 32'(stall0), 0);
        chk("reset_fwd_a", 32'(fa0), 0);
        chk("reset_fwd_b", 32'(fb0), 0);
        chk("reset_ex_rd", 32'(exrd0), 0);
        chk("reset_ex_rd1", 32'(exrd1), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // load-use: one bubble, then WB forward
        step(lw5, 1'b0);
        chk("lw_no_stall", 32'(last_stall0), 0);
        hold(add6, 1'b0, ns);
        chk("loaduse_stall_cycles", ns, 1);
        step(nop, 1'b0);
        chk("loaduse_fwd_a_wb", 32'(last_fa0), 2);
        chk("loaduse_fwd_b", 32'(last_fb0), 0);
        chk("loaduse_ex_rd", 32'(last_exrd0), 6);
        drain();

        // ALU producer forwarded from MEM to both operands
        step(add5a, 1'b0);
        step(sub7, 1'b0);
        chk("alu_no_stall", 32'(last_stall0), 0);
        chk("alu_no_stall1", 32'(last_stall1), 0);
        step(nop, 1'b0);
        chk("alu_fwd_a_mem", 32'(last_fa0), 1);
        chk("alu_fwd_b_mem", 32'(last_fb0), 1);
        chk("alu_fwd_a1_mem", 32'(last_fa1), 1);
        chk("alu_ex_rd", 32'(last_exrd0), 7);
        drain();

        // youngest producer wins; x0 never forwards or stalls
        step(add5a, 1'b0);
        step(add5b, 1'b0);
        step(or8, 1'b0);
        step(nop, 1'b0);
        chk("youngest_fwd_a", 32'(last_fa0), 1);
        chk("x0_fwd_b", 32'(last_fb0), 0);
        step(lw0, 1'b0);
        step(add9, 1'b0);
        chk("x0_no_stall", 32'(last_stall0), 0);
        step(nop, 1'b0);
        chk("x0_fwd_a", 32'(last_fa0), 0);
        chk("x0_ex_rd", 32'(last_exrd0), 9);
        drain();

        // flush overrides stall and injects a bubble
`ifdef HAZARD_STATS_EN
        c0 = fcnt0;
`endif
        step(lw5, 1'b0);
        step(add6, 1'b1);
        chk("flush_no_stall", 32'(last_stall0), 0);
        chk("flush_no_stall1", 32'(last_stall1), 0);
        step(nop, 1'b0);
        chk("flush_bubble_ex_rd", 32'(last_exrd0), 0);
        chk("flush_bubble_ex_rd1", 32'(last_exrd1), 0);
`ifdef HAZARD_STATS_EN
        chk("flush_cnt_delta", fcnt0 - c0, 1);
`endif
        drain();

        // LOAD_STAGE=2, FWD_STAGES=4: two bubbles, then stage 3 forward
        step(lw3, 1'b0);
        hold(add4, 1'b1, ns);
        chk("ls2_stall_cycles", ns, 2);
        step(nop, 1'b0);
        chk("ls2_fwd_a", 32'(last_fa1), 3);
        chk("ls2_fwd_b", 32'(last_fb1), 3);
        drain();

        // asynchronous reset in the middle of a stall
        step(lw5, 1'b0);
        set_id(add6, 1'b0);
        #2;
        chk("prerst_stall", 32'(stall0), 1);
        chk("prerst_ex_rd", 32'(exrd0), 5);
        rst = 1'b0;
        #1;
        chk("rst_stall", 32'(stall0), 0);
        chk("rst_fwd_a", 32'(fa0), 0);
        chk("rst_fwd_b", 32'(fb0), 0);
        chk("rst_ex_rd", 32'(exrd0), 0);
        chk("rst_stall1", 32'(stall1), 0);
        chk("rst_ex_rd1", 32'(exrd1), 0);
        @(negedge clk);
        compare_all();
`ifdef HAZARD_STATS_EN
        chk("rst_stall_cnt", scnt0, 0);
        chk("rst_flush_cnt", fcnt0, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(add6, 1'b0);
        drain();

`ifdef HAZARD_STATS_EN
        c0 = scnt0;
        repeat (5) begin
            step(lw5, 1'b0);
            hold(add6, 1'b0, ns);
        end
        chk("stall_cnt_five", scnt0 - c0, 5);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed interlock and forwarding pair in the 5-stage RISC-V core.
- Tracks in-flight destination registers for every stage after decode in an internal shift scoreboard.
- Generates the decode stall (load-use, for any load latency), the EX operand forwarding selects and the decode bubble on a taken branch.
- Sits beside Instruction_Decoding and Execution. Replaces the separate Interlock_Unit and data_forwarding.

Parameters:
- AW, 5, register address width (2^AW architectural registers; register 0 is hard-wired zero).
- FWD_STAGES, 3, pipeline stages tracked from EX onward (stage 0 = EX, stage FWD_STAGES-1 = WB); legal 2..8.
- LOAD_STAGE, 1, stage index whose output first carries load data; legal 0..FWD_STAGES-2.
- FSW, $clog2(FWD_STAGES), width of the forward select. Derived; not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  a real instruction is in ID.
- id_rs1, id_rs2  in  AW  ID source registers.
- id_rs1_used, id_rs2_used  in  1  the source is actually read.
- id_rd  in  AW  ID destination register.
- id_regwrite  in  1  the ID instruction writes rd.
- id_memread  in  1  the ID instruction is a load.
- flush  in  1  branch taken in EX this cycle.
- stall  out  1  hold IF/ID and PC; inject a bubble into EX.
- fwd_a, fwd_b  out  FSW  EX operand source: 0 = register file, k = result of stage k (1..FWD_STAGES-1).
- ex_rd  out  AW  rd of the instruction currently in EX. Feeds the existing rd path.

Behaviour:
- Scoreboard: FWD_STAGES entries of {valid, rd, regwrite, load}, plus ex_rs1, ex_rs2, ex_rs1_used and ex_rs2_used for stage 0. All cleared on reset.
- Every clock the scoreboard shifts: entry k moves to k+1 and entry FWD_STAGES-1 is discarded. The pipeline after ID never stalls.
- Entry 0 load:
  - the ID fields when id_valid=1, stall=0 and flush=0;
  - otherwise a bubble (all zero).
- Producer match at stage k: valid, regwrite, rd != 0 and rd equal to the source being checked.
- stall (combinational):
  - 1 when id_valid=1, flush=0, and a used ID source matches a stage-k producer with load=1 and k < LOAD_STAGE;
  - 0 otherwise.
  - For LOAD_STAGE=1 this gives exactly one bubble per load-use.
  - flush overrides stall.
- fwd_a/fwd_b (combinational, from registered state):
  - select the smallest k in 1..FWD_STAGES-1 whose producer matches ex_rs1 / ex_rs2, and whose source is used;
  - if none match, select 0;
  - the youngest producer wins; register 0 always selects 0.
- ex_rd = entry 0 rd when entry 0 is valid and regwrite=1, else 0.
- Simultaneous stall and flush: flush wins, stall=0, bubble enters EX.
- Reset mid-operation: all entries become invalid at once. Outputs are 0 while rst=0.
- Reset values: stall=0, fwd_a=0, fwd_b=0, ex_rd=0.
- Back-to-back loads to the same rd: the younger one governs the stall. No double counting.
- Producers in the WB stage are forwarded. Register-file write-before-read is not required.

Optional Feature:
- HAZARD_STATS_EN defined:
  - adds output ports stall_cnt[31:0] and flush_cnt[31:0];
  - each cycle, stall_cnt increments if stall=1 and flush_cnt increments if flush=1;
  - both saturate at 32'hFFFF_FFFF;
  - both reset to 0 on rst.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Defaults. lw x5 then add x6,x5,x1 on consecutive cycles -> stall=1 for exactly 1 cycle; when the add reaches EX, fwd_a=2 (WB).
- add x5 then sub x7,x5,x5 -> stall never asserts; when the sub is in EX, fwd_a=1 and fwd_b=1 (MEM).
- add x5 / add x5 / or x8,x5,x0 -> or in EX: fwd_a=1 (youngest wins), fwd_b=0; ID instruction writing x0 never causes a stall or forward.
- lw x5 then dependent add, with flush=1 in the stall cycle -> stall=0, a bubble enters EX, ex_rd=0 on the next cycle.
- LOAD_STAGE=2, FWD_STAGES=4: lw x3 then a dependent instruction -> stall for 2 cycles, then fwd select 3.
- rst pulsed low during a stall -> stall, fwd_a, fwd_b and ex_rd drop to 0 immediately. With HAZARD_STATS_EN: 5 stall cycles give stall_cnt=5; a preload at 32'hFFFF_FFFE followed by 3 stalls gives stall_cnt=32'hFFFF_FFFF.
